// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings and the per-stage control word for the ctrl_pipe control unit.
package ctrl_pipe_pkg;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_OUT     = 2'd1;
    localparam logic [1:0] OP_SPECIAL = 2'd2;
    localparam logic [1:0] OP_STORE   = 2'd3;

    localparam logic [1:0] FN_ADD  = 2'd0;
    localparam logic [1:0] FN_SUB  = 2'd1;
    localparam logic [1:0] FN_CMP  = 2'd2;
    localparam logic [1:0] FN_JUMP = 2'd3;

    // Field widths are upper bounds; instances use the low FW / RAW bits.
    localparam int CTRL_FW_MAX  = 8;
    localparam int CTRL_RAW_MAX = 8;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    alu_src;
        logic [CTRL_FW_MAX-1:0]  alu_op;
        logic                    cmp;
        logic                    out_en;
        logic                    jump;
        logic [CTRL_RAW_MAX-1:0] rd;
        logic                    valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle between the fetch/decode latch, ctrl_pipe and the datapath stage registers.
interface ctrl_pipe_if #(
    parameter int OPW  = 2,
    parameter int FW   = 2,
    parameter int RAW  = 2,
    parameter int CNTW = 16
);
    logic            instr_valid;
    logic [OPW-1:0]  opcode;
    logic [FW-1:0]   funct;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;

    logic            stall;
    logic            flush;
    logic            ex_alu_src;
    logic [FW-1:0]   ex_alu_op;
    logic            ex_cmp;
    logic            mem_read;
    logic            mem_write;
    logic            wb_reg_write;
    logic            wb_out_en;
    logic [RAW-1:0]  wb_rd;
    logic            illegal_op;
    logic [CNTW-1:0] retired_cnt;

    modport master (
        output instr_valid, opcode, funct, rd, rs1, rs2,
        input  stall, flush, ex_alu_src, ex_alu_op, ex_cmp, mem_read, mem_write,
               wb_reg_write, wb_out_en, wb_rd, illegal_op, retired_cnt
    );

    modport slave (
        input  instr_valid, opcode, funct, rd, rs1, rs2,
        output stall, flush, ex_alu_src, ex_alu_op, ex_cmp, mem_read, mem_write,
               wb_reg_write, wb_out_en, wb_rd, illegal_op, retired_cnt
    );

endinterface

// File: rtl/ctrl_pipe_decode.sv
// Combinational instruction decoder: opcode/funct/rd to a control word plus register-read flags.
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int OPW = 2,
    parameter int FW  = 2,
    parameter int RAW = 2
) (
    input  logic [OPW-1:0] opcode,
    input  logic [FW-1:0]  funct,
    input  logic [RAW-1:0] rd,
    output ctrl_t          ctrl,
    output logic           uses_rs1,
    output logic           uses_rs2,
    output logic           illegal
);

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        // Any opcode bit above the two defined ones makes the instruction illegal.
        illegal  = |(opcode >> 2);

        ctrl.valid = 1'b1;
        ctrl.rd    = CTRL_RAW_MAX'(rd);
        case (opcode[1:0])
            OP_LOAD: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_OUT: begin
                ctrl.out_en = 1'b1;
                uses_rs1    = 1'b1;
            end
            OP_SPECIAL: begin
                if (|(funct >> 2)) begin
                    illegal = 1'b1;
                end
                case (funct[1:0])
                    FN_ADD, FN_SUB: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_op    = CTRL_FW_MAX'(funct);
                        uses_rs1       = 1'b1;
                        uses_rs2       = 1'b1;
                    end
                    FN_CMP: begin
                        ctrl.cmp = 1'b1;
                        uses_rs1 = 1'b1;
                        uses_rs2 = 1'b1;
                    end
                    FN_JUMP: begin
                        ctrl.jump = 1'b1;
                    end
                endcase
            end
        endcase

        if (illegal) begin
            ctrl     = CTRL_BUBBLE;
            uses_rs1 = 1'b0;
            uses_rs2 = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode, EX/MEM/WB control registers, load-use stall, jump flush, retire count.
// Build option: CTRL_PIPE_HAZARD_EN enables load-use detection; without it stall is tied low.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int OPW  = 2,
    parameter int FW   = 2,
    parameter int RAW  = 2,
    parameter int CNTW = 16
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    ctrl_t           dec_ctrl;
    logic            dec_rs1;
    logic            dec_rs2;
    logic            dec_illegal;

    ctrl_t           ctrl_p0;
    ctrl_t           ctrl_p1;
    ctrl_t           ctrl_p2;
    logic            flush_q;
    logic            illegal_q;
    logic [CNTW-1:0] retired_q;

    logic            hazard;
    logic            accept;
    logic            unused_bits;

    ctrl_decode #(
        .OPW (OPW),
        .FW  (FW),
        .RAW (RAW)
    ) u_decode (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .rd       (bus.rd),
        .ctrl     (dec_ctrl),
        .uses_rs1 (dec_rs1),
        .uses_rs2 (dec_rs2),
        .illegal  (dec_illegal)
    );

`ifdef CTRL_PIPE_HAZARD_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = dec_rs1 && (CTRL_RAW_MAX'(bus.rs1) == ctrl_p0.rd);
    assign rs2_hit = dec_rs2 && (CTRL_RAW_MAX'(bus.rs2) == ctrl_p0.rd);
    // A LOAD in EX has not fetched its data yet; a reader right behind it must wait one cycle.
    assign hazard  = ctrl_p0.valid && ctrl_p0.mem_read && bus.instr_valid && (rs1_hit || rs2_hit);
`else
    assign hazard  = 1'b0;
`endif

    // Flush wins over stall; illegal instructions enter as bubbles.
    assign accept = bus.instr_valid && !hazard && !flush_q && !dec_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p0 <= CTRL_BUBBLE;
            ctrl_p1 <= CTRL_BUBBLE;
            ctrl_p2 <= CTRL_BUBBLE;
            flush_q <= 1'b0;
        end else begin
            // decode -> EX
            ctrl_p0 <= accept ? dec_ctrl : CTRL_BUBBLE;
            flush_q <= accept && dec_ctrl.jump;
            // EX -> MEM
            ctrl_p1 <= ctrl_p0;
            // MEM -> WB
            ctrl_p2 <= ctrl_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (bus.instr_valid && !flush_q && dec_illegal) begin
                illegal_q <= 1'b1;
            end
            if (ctrl_p2.valid) begin
                retired_q <= retired_q + CNTW'(1);
            end
        end
    end

    assign bus.stall        = hazard;
    assign bus.flush        = flush_q;
    assign bus.ex_alu_src   = ctrl_p0.alu_src;
    assign bus.ex_alu_op    = ctrl_p0.alu_op[FW-1:0];
    assign bus.ex_cmp       = ctrl_p0.cmp;
    assign bus.mem_read     = ctrl_p1.mem_read;
    assign bus.mem_write    = ctrl_p1.mem_write;
    assign bus.wb_reg_write = ctrl_p2.reg_write;
    assign bus.wb_out_en    = ctrl_p2.out_en;
    assign bus.wb_rd        = ctrl_p2.rd[RAW-1:0];
    assign bus.illegal_op   = illegal_q;
    assign bus.retired_cnt  = retired_q;

    // Stage fields not consumed at every stage, and source fields unused without hazard detection.
    assign unused_bits = ^{ctrl_p0, ctrl_p2, dec_rs1, dec_rs2, bus.rs1, bus.rs2};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: vector table for straight-line decode, hand sequences for corner cases.
module tb_ctrl_pipe;

    localparam int OPW  = 3;
    localparam int FW   = 2;
    localparam int RAW  = 2;
    localparam int CNTW = 2;
`ifdef CTRL_PIPE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.OPW(OPW), .FW(FW), .RAW(RAW), .CNTW(CNTW)) bus ();

    ctrl_pipe #(
        .OPW  (OPW),
        .FW   (FW),
        .RAW  (RAW),
        .CNTW (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Inputs, then stall/flush before the edge, then stage outputs after the edge.
    typedef struct {
        int iv, op, fn, rd, rs1, rs2;
        int stall, flush;
        int ex_src, ex_op, ex_cmp, m_rd, m_wr, w_rw, w_out, w_rd, ill, cnt;
    } vec_t;

    vec_t tv[13];

    function automatic logic [12:0] obs();
        return {bus.ex_alu_src, bus.ex_alu_op, bus.ex_cmp, bus.mem_read, bus.mem_write,
                bus.wb_reg_write, bus.wb_out_en, bus.wb_rd, bus.illegal_op, bus.retired_cnt};
    endfunction

    function automatic logic [12:0] expect_of(input vec_t v);
        return {1'(v.ex_src), 2'(v.ex_op), 1'(v.ex_cmp), 1'(v.m_rd), 1'(v.m_wr),
                1'(v.w_rw), 1'(v.w_out), 2'(v.w_rd), 1'(v.ill), 2'(v.cnt)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int op, input int fn, input int rd, input int rs1, input int rs2);
        bus.instr_valid = 1'b1;
        bus.opcode      = OPW'(op);
        bus.funct       = FW'(fn);
        bus.rd          = RAW'(rd);
        bus.rs1         = RAW'(rs1);
        bus.rs2         = RAW'(rs2);
    endtask

    task automatic idle();
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.funct       = '0;
        bus.rd          = '0;
        bus.rs1         = '0;
        bus.rs2         = '0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nst;
        logic acc;
        logic st;
        logic seen;

        idle();
        rst = 1'b1;

        //        iv op fn rd s1 s2  st fl  src aop cmp mrd mwr wrw wout wrd ill cnt
        tv[0]  = '{1, 2, 0, 1, 2, 3,  0, 0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  0};  // ADD r1
        tv[1]  = '{1, 2, 1, 2, 1, 1,  0, 0,  0,  1,  0,  0,  0,  0,  0,   0,  0,  0};  // SUB r2
        tv[2]  = '{1, 1, 0, 0, 1, 0,  0, 0,  0,  0,  0,  0,  0,  1,  0,   1,  0,  0};  // OUT
        tv[3]  = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  1,  0,   2,  0,  1};
        tv[4]  = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  0,  1,   0,  0,  2};
        tv[5]  = '{1, 3, 0, 0, 3, 0,  0, 0,  1,  0,  0,  0,  0,  0,  0,   0,  0,  3};  // STORE
        tv[6]  = '{1, 2, 2, 0, 1, 2,  0, 0,  0,  0,  1,  0,  1,  0,  0,   0,  0,  3};  // CMP
        tv[7]  = '{1, 0, 0, 3, 0, 0,  0, 0,  1,  0,  0,  0,  0,  0,  0,   0,  0,  3};  // LOAD r3
        tv[8]  = '{1, 2, 0, 1, 0, 1,  0, 0,  0,  0,  0,  1,  0,  0,  0,   0,  0,  0};  // ADD, no dep
        tv[9]  = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  1,  0,   3,  0,  1};
        tv[10] = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  1,  0,   1,  0,  2};
        tv[11] = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  3};
        tv[12] = '{0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0,  0,  0,  0,  0,   0,  0,  3};

        #12;
        chk("reset_outputs", 32'(obs()), 32'(0));
        chk("reset_stall_flush", 32'({bus.stall, bus.flush}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (tv[i].iv != 0) put(tv[i].op, tv[i].fn, tv[i].rd, tv[i].rs1, tv[i].rs2);
            else idle();
            #1;
            chk($sformatf("row%0d_stall_flush", i), 32'({bus.stall, bus.flush}),
                32'({1'(tv[i].stall), 1'(tv[i].flush)}));
            tick();
            chk($sformatf("row%0d_outputs", i), 32'(obs()), 32'(expect_of(tv[i])));
        end

        // Load-use: LOAD r2 then ADD r1 = r2 + r0
        reset_dut();
        put(0, 0, 2, 0, 0);
        tick();
        put(2, 0, 1, 2, 0);
        nst = 0;
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) begin
            #1;
            st = bus.stall;
            if (st) nst++;
            tick();
            if (!st) acc = 1'b1;
        end
        idle();
        chk("loaduse_stall_cycles", 32'(nst), HZ ? 32'(1) : 32'(0));
        chk("loaduse_accepted", 32'(acc), 32'(1));
        chk("loaduse_at_accept", 32'({bus.mem_read, bus.wb_reg_write, bus.wb_rd}),
            HZ ? 32'(4'b0_1_10) : 32'(4'b1_0_00));
        tick();
        chk("loaduse_bubble", 32'({bus.wb_reg_write, bus.wb_rd}), HZ ? 32'(3'b0_00) : 32'(3'b1_10));
        tick();
        chk("loaduse_add_wb", 32'({bus.wb_reg_write, bus.wb_rd}), 32'(3'b1_01));
        tick();
        chk("loaduse_cnt", 32'(bus.retired_cnt), 32'(2));

        // Jump followed by an ADD that must be discarded
        reset_dut();
        put(2, 3, 0, 0, 0);
        #1;
        chk("jump_flush_before", 32'(bus.flush), 32'(0));
        tick();
        put(2, 0, 1, 0, 0);
        #1;
        chk("jump_flush_high", 32'({bus.flush, bus.stall}), 32'(2'b10));
        tick();
        idle();
        #1;
        chk("jump_flush_one_cycle", 32'(bus.flush), 32'(0));
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.wb_reg_write) seen = 1'b1;
        end
        chk("jump_add_dropped", 32'(seen), 32'(0));
        chk("jump_cnt", 32'(bus.retired_cnt), 32'(1));

        // Illegal opcode, then ten legal instructions
        reset_dut();
        chk("illegal_after_reset", 32'(bus.illegal_op), 32'(0));
        put(5, 0, 1, 0, 0);
        tick();
        idle();
        chk("illegal_bubble", 32'(obs()), 32'(13'b0_00_0_0_0_0_0_00_1_00));
        for (int k = 0; k < 10; k++) begin
            put(2, 0, 1, 0, 0);
            tick();
            chk($sformatf("illegal_sticky_%0d", k), 32'(bus.illegal_op), 32'(1));
        end
        idle();
        tick();
        tick();
        tick();
        chk("illegal_cnt", 32'({bus.illegal_op, bus.retired_cnt}), 32'(3'b1_10));

        // Reset with three instructions in flight
        reset_dut();
        put(2, 0, 1, 0, 0);
        tick();
        put(0, 0, 3, 0, 0);
        tick();
        put(3, 0, 0, 1, 0);
        tick();
        idle();
        chk("inflight", 32'(obs()), 32'(13'b1_00_0_1_0_1_0_01_0_00));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(obs()), 32'(0));
        chk("rst_async_stall_flush", 32'({bus.stall, bus.flush}), 32'(0));
        #1;
        rst = 1'b0;
        put(0, 0, 2, 0, 0);
        tick();
        idle();
        chk("first_accept_after_release", 32'(bus.ex_alu_src), 32'(1));
        tick();
        tick();
        chk("post_reset_wb", 32'({bus.wb_reg_write, bus.wb_rd, bus.retired_cnt}), 32'(5'b1_10_00));
        tick();
        chk("post_reset_cnt", 32'(bus.retired_cnt), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipelined control unit for the small pipelined CPU. It decodes one instruction per cycle into a control word and carries that word through EX, MEM and WB stage registers. It detects load-use hazards and stalls the front end, flushes the front end on JUMP, flags illegal opcodes, and counts retired instructions. It sits between the fetch/decode latch and the datapath stage registers.

## Interface
- OPW, 2, opcode width; values above 3 are illegal
- FW, 2, funct width
- RAW, 2, register address width
- CNTW, 16, retired-instruction counter width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction presented this cycle
- opcode  in  OPW  0 LOAD, 1 OUT, 2 SPECIAL, 3 STORE
- funct  in  FW  SPECIAL only: 0 ADD, 1 SUB, 2 CMP, 3 JUMP; upper bits must be 0, otherwise illegal
- rd, rs1, rs2  in  RAW each  destination and source register addresses
- stall  out  1  front end must hold its instruction (combinational)
- flush  out  1  front end must discard the instruction presented this cycle (registered)
- ex_alu_src, ex_alu_op[FW], ex_cmp  out  EX-stage controls
- mem_read, mem_write  out  1 each  MEM-stage controls
- wb_reg_write, wb_out_en  out  1 each; wb_rd  out  RAW  WB-stage controls
- illegal_op  out  1  sticky illegal-instruction flag
- retired_cnt  out  CNTW  count of instructions leaving WB

## Operation
- Decode per opcode:
  - LOAD: reg_write, mem_read, alu_src; reads no registers.
  - STORE: mem_write, alu_src; reads rs1.
  - OUT: out_en; reads rs1.
  - ADD/SUB: reg_write; alu_op=funct; reads rs1 and rs2.
  - CMP: cmp; reads rs1 and rs2.
  - JUMP: no datapath control; reads no registers.
- Acceptance: the instruction is accepted when instr_valid=1, stall=0 and flush=0. Otherwise a bubble (all controls 0, stage valid 0) enters EX.
- Illegal instruction: the instruction becomes a bubble and illegal_op is set at the next edge. illegal_op holds until reset.
- Stage valids and control words shift EX→MEM→WB every cycle. The pipeline never freezes; stall only blocks acceptance.
- Hazard: stall=1 when all of these hold:
  - EX holds a valid LOAD;
  - instr_valid=1;
  - the incoming instruction reads a register equal to ex rd.
- Flush: flush=1 for exactly the cycle in which a valid JUMP occupies EX.
- Priority: flush overrides stall. A cycle with both active injects a bubble.
- Counter: retired_cnt increments when WB holds a valid instruction. Bubbles do not count. The counter wraps modulo 2^CNTW.
- Reset: asynchronous. It clears every stage valid and control, stall, flush, illegal_op and retired_cnt to 0 immediately. In-flight instructions are lost without retiring.

## Timing
- Instruction accepted at edge n:
  - EX outputs valid after edge n;
  - MEM outputs valid after edge n+1;
  - WB outputs valid after edge n+2;
  - retired_cnt increments at edge n+3.
- Load-use: stall is high for exactly one cycle, then the held instruction is accepted on the next edge. Net penalty: one bubble.
- JUMP accepted at edge n: flush is high during cycle n+1. The instruction presented then is dropped, and EX receives a bubble at edge n+1.
- Back-to-back JUMPs cannot occur, because the second is always flushed.
- rst deassertion: the first accept is possible at the first rising edge after release.

## Configuration
- CTRL_PIPE_HAZARD_EN defined: load-use detection and stall generation as above.
- CTRL_PIPE_HAZARD_EN undefined:
  - stall is tied to 0;
  - the compiler must schedule a gap after each LOAD;
  - a dependent instruction issued directly after a LOAD reads stale data, with no flag raised.
- Flush, illegal detection and counting are unaffected by the macro.

## Structure
- Package ctrl_pipe_pkg:
  - opcode and funct localparams;
  - packed struct ctrl_t (reg_write, mem_read, mem_write, alu_src, alu_op, cmp, out_en, jump, rd, valid);
  - constant CTRL_BUBBLE (all zeros).
- Sub-module ctrl_decode: purely combinational. Maps opcode/funct/rd to ctrl_t, plus uses_rs1, uses_rs2 and illegal. Instantiated once.

## Test plan
- Reset mid-stream: raise rst with three instructions in flight → all outputs 0 within the same cycle; retired_cnt=0.
- Straight-line: accept ADD rd=1, then SUB, then OUT → wb_reg_write=1, wb_rd=1 three edges after the ADD; retired_cnt=3 after all retire.
- Load-use: LOAD rd=2, then ADD rs1=2 → stall=1 for one cycle, one bubble in EX, ADD accepted on the following edge. Without the macro → stall stays 0.
- Jump: JUMP, then ADD presented the next cycle → flush=1 in that cycle, ADD never reaches WB, retired_cnt increments by 1 only.
- Illegal: OPW=3, opcode=5 → no controls asserted, illegal_op=1 and it stays 1 through 10 further legal instructions.
- Wrap: CNTW=2, retire 5 instructions → retired_cnt=1.
